// File: rtl/bip_pkg.sv
// Shared definitions for the BIP debug unit: FSM states, default command
// bytes and the field byte-count helper.
package bip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    localparam logic [7:0] CMD_RUN_DEF  = 8'h52;
    localparam logic [7:0] CMD_STEP_DEF = 8'h53;
    localparam logic [7:0] CMD_DUMP_DEF = 8'h44;

    function automatic int unsigned nbytes(input int unsigned w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/bip_snapshot_serializer.sv
// Latches {CNT, ACC, PC} (each zero-padded to whole bytes) and shifts it out
// one byte per advance, LSB first, flagging the final byte.
module bip_snapshot_serializer
    import bip_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [CNT_WIDTH-1:0]  cnt,
    output logic [7:0]            byte_out,
    output logic                  last
);

    localparam int unsigned PC_BITS  = nbytes(PC_WIDTH) * 8;
    localparam int unsigned ACC_BITS = nbytes(DATA_WIDTH) * 8;
    localparam int unsigned CNT_BITS = nbytes(CNT_WIDTH) * 8;
    localparam int unsigned NBYTES   = nbytes(PC_WIDTH) + nbytes(DATA_WIDTH) + nbytes(CNT_WIDTH);
    localparam int unsigned SR_BITS  = NBYTES * 8;
    localparam int unsigned REM_W    = $clog2(NBYTES + 1);

    logic [SR_BITS-1:0] sr_q, sr_d;
    logic [REM_W-1:0]   rem_q, rem_d;

    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        if (load) begin
            sr_d  = {CNT_BITS'(cnt), ACC_BITS'(acc), PC_BITS'(pc)};
            rem_d = REM_W'(NBYTES);
        end else if (advance) begin
            sr_d = sr_q >> 8;
            if (rem_q != '0) begin
                rem_d = rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            rem_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
        end
    end

    assign byte_out = sr_q[7:0];
    assign last     = (rem_q == REM_W'(1));

endmodule

// File: rtl/bip_debug_unit.sv
// UART-side debug controller for BIP: run/step/dump command decoding, enabled
// cycle counter and snapshot packet transmission.
module bip_debug_unit
    import bip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PC_WIDTH   = 11,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter logic [7:0]  CMD_RUN    = CMD_RUN_DEF,
    parameter logic [7:0]  CMD_STEP   = CMD_STEP_DEF,
    parameter logic [7:0]  CMD_DUMP   = CMD_DUMP_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  cpu_enable,
    input  logic                  finish_program,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [DATA_WIDTH-1:0] acc,
    output logic                  halted
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 halted_q, halted_d;
    logic                 gap_q, gap_d;
    logic                 load, advance, ser_last;
    logic [7:0]           ser_byte;

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        gap_d      = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        cpu_enable = (state_q == ST_RUN) || (state_q == ST_STEP);
        tx_start   = (state_q == ST_SEND);
        cnt_d      = (cpu_enable && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_RUN && !halted_q) begin
                        state_d = ST_RUN;
                    end else if (rx_data == CMD_STEP && !halted_q) begin
                        state_d = ST_STEP;
                    end else if (rx_data == CMD_DUMP) begin
                        load    = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_RUN: begin
                if (finish_program) begin
                    halted_d = 1'b1;
                    load     = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_STEP: begin
                if (finish_program) begin
                    halted_d = 1'b1;
                end
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                // Shift on tx_done, then hold one extra cycle before SEND.
                if (gap_q) begin
                    state_d = ST_SEND;
                end else if (tx_done) begin
                    advance = 1'b1;
                    if (ser_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            gap_q    <= gap_d;
        end
    end

    bip_snapshot_serializer #(
        .PC_WIDTH  (PC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .pc      (pc),
        .acc     (acc),
        .cnt     (cnt_d),
        .byte_out(ser_byte),
        .last    (ser_last)
    );

    assign tx_data = ser_byte;
    assign halted  = halted_q;

endmodule
